zap_memory_bus_if: RTL and testbench

ZAP_MEMORY_BUS_IF -- requirements
Module: zap_memory_bus_if

---
 rtl/zap_memory_bus_if_pkg.sv | 19 +
 rtl/zap_memory_bus_if_if.sv | 23 ++
 rtl/zap_memory_bus_if_lane_gen.sv | 37 +++
 rtl/zap_memory_bus_if.sv | 147 ++++++++++++++
 tb/tb_zap_memory_bus_if.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/zap_memory_bus_if_pkg.sv
// Shared definitions for the ZAP memory-stage bus interface: FSM states, access size codes, timeout default.
// The optional bus timeout is enabled by defining ZAP_MEM_TIMEOUT_EN.
package zap_memory_bus_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 32'd255;

endpackage

// File: rtl/zap_memory_bus_if_if.sv
// Wishbone-style bus bundle between the memory stage (master) and the memory system (slave).
interface zap_memory_bus_if_if;

  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_dat;

  modport master (
    output o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    input  i_wb_ack, i_wb_err, i_wb_dat
  );

  modport slave (
    input  o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    output i_wb_ack, i_wb_err, i_wb_dat
  );

endinterface

// File: rtl/zap_memory_bus_if_lane_gen.sv
// Byte-lane enables, store-data replication and misalignment detection for one access.
module zap_mem_lane_gen
  import zap_memory_bus_if_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  sel,
  output logic [31:0] dat,
  output logic        misaligned
);

  // Reserved size code falls through to the word rules.
  always_comb begin
    sel        = 4'b1111;
    dat        = wdata;
    misaligned = 1'b0;
    case (size)
      SIZE_HALF: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        dat        = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SIZE_BYTE: begin
        sel        = 4'b0001 << addr_lo;
        dat        = {4{wdata[7:0]}};
        misaligned = 1'b0;
      end
      default: begin
        sel        = 4'b1111;
        dat        = wdata;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/zap_memory_bus_if.sv
// ZAP memory-stage bus master: one outstanding access, flush-safe draining, optional
// bus timeout fault when ZAP_MEM_TIMEOUT_EN is defined.
module zap_memory_bus_if
  import zap_memory_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_req,
  input  logic        i_load,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  output logic        o_data_stall,
  output logic [31:0] o_mem_rd_data,
  output logic        o_mem_fault,
  zap_memory_bus_if_if.master wb
);

  mem_state_e  state_r, state_nxt_s;
  logic        accept_s, misalign_s, bus_end_s, bus_fault_s, timeout_s, fault_nxt_s;
  logic [3:0]  lane_sel_s;
  logic [31:0] lane_dat_s;
  logic        stb_r, we_r, fault_r;
  logic [31:0] adr_r, dat_r, rd_r;
  logic [3:0]  sel_r;

  zap_mem_lane_gen u_lane_gen (
    .addr_lo    (i_addr[1:0]),
    .size       (i_size),
    .wdata      (i_wdata),
    .sel        (lane_sel_s),
    .dat        (lane_dat_s),
    .misaligned (misalign_s)
  );

  assign accept_s    = (state_r == ST_IDLE) && i_req && !i_clear_from_writeback;
  assign bus_end_s   = wb.i_wb_ack | wb.i_wb_err | timeout_s;
  // Only meaningful when bus_end_s: err beats ack, and an end without ack is a timeout.
  assign bus_fault_s = wb.i_wb_err | ~wb.i_wb_ack;

`ifdef ZAP_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [CNT_W-1:0] tmo_cnt_r;

  assign timeout_s = (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));

  // Counts consecutive bus-owning cycles of the current access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_BUS || state_r == ST_DRAIN) &&
                 (state_nxt_s == ST_BUS || state_nxt_s == ST_DRAIN)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Next-state logic; a flush that coincides with bus completion needs no drain.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = misalign_s ? ST_DONE : ST_BUS;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_end_s)                   state_nxt_s = i_clear_from_writeback ? ST_IDLE : ST_DONE;
        else if (i_clear_from_writeback) state_nxt_s = ST_DRAIN;
        else                             state_nxt_s = ST_BUS;
      end
      ST_DRAIN: begin
        if (bus_end_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Stall and result-fault selection per state.
  always_comb begin
    o_data_stall = 1'b0;
    fault_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        o_data_stall = accept_s;
        fault_nxt_s  = misalign_s;
      end
      ST_BUS: begin
        o_data_stall = 1'b1;
        fault_nxt_s  = bus_fault_s;
      end
      ST_DRAIN: begin
        o_data_stall = 1'b1;
        fault_nxt_s  = 1'b0;
      end
      default: begin
        o_data_stall = 1'b0;
        fault_nxt_s  = 1'b0;
      end
    endcase
  end

  // Registered bus request and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stb_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= 32'd0;
      dat_r   <= 32'd0;
      sel_r   <= 4'd0;
      rd_r    <= 32'd0;
      fault_r <= 1'b0;
    end else begin
      stb_r   <= (state_nxt_s == ST_BUS) || (state_nxt_s == ST_DRAIN);
      fault_r <= (state_nxt_s == ST_DONE) && fault_nxt_s;
      if (state_nxt_s == ST_DONE) rd_r <= fault_nxt_s ? 32'd0 : wb.i_wb_dat;
      if (accept_s) begin
        adr_r <= {i_addr[31:2], 2'b00};
        dat_r <= lane_dat_s;
        sel_r <= lane_sel_s;
        we_r  <= ~i_load;
      end
    end
  end

  assign wb.o_wb_stb   = stb_r;
  assign wb.o_wb_we    = we_r;
  assign wb.o_wb_adr   = adr_r;
  assign wb.o_wb_dat   = dat_r;
  assign wb.o_wb_sel   = sel_r;
  assign o_mem_rd_data = rd_r;
  assign o_mem_fault   = fault_r & ~i_clear_from_writeback;

endmodule

// File: tb/tb_zap_memory_bus_if.sv
// Randomised and directed bench for zap_memory_bus_if against an access-level reference model.
module tb_zap_memory_bus_if;

  localparam int TMO = 4;
`ifdef ZAP_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clr, req, ld;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        stall, fault;
  logic [31:0] rd;
  int          total = 0, bad = 0, stall_hi = 0;

  // Reference model: where the access is, and what the pipeline must see.
  bit          m_bus, m_drain, m_done, m_fault, m_we;
  int          m_age;
  logic [31:0] m_rd, m_adr, m_dat;
  logic [3:0]  m_sel;

  zap_memory_bus_if_if bus ();

  zap_memory_bus_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_clear_from_writeback (clr),
    .i_req                  (req),
    .i_load                 (ld),
    .i_addr                 (addr),
    .i_wdata                (wdata),
    .i_size                 (size),
    .o_data_stall           (stall),
    .o_mem_rd_data          (rd),
    .o_mem_fault            (fault),
    .wb                     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare every meaningful DUT output with the model for the current cycle.
  task automatic compare();
    chk("stall", {31'd0, stall}, {31'd0, m_bus || (!m_done && req && !clr)});
    chk("stb", {31'd0, bus.o_wb_stb}, {31'd0, m_bus});
    chk("fault", {31'd0, fault}, {31'd0, m_done && m_fault && !clr});
    chk("rd_data", rd, m_rd);
    if (m_bus) begin
      chk("adr", bus.o_wb_adr, m_adr);
      chk("dat", bus.o_wb_dat, m_dat);
      chk("sel", {28'd0, bus.o_wb_sel}, {28'd0, m_sel});
      chk("we", {31'd0, bus.o_wb_we}, {31'd0, m_we});
    end
    if (stall) stall_hi++;
  endtask

  // Advance the model by one clock using the inputs that were presented.
  task automatic model_edge();
    bit fin, ack, err;
    ack = bus.i_wb_ack;
    err = bus.i_wb_err;
    if (rst) begin
      m_bus = 0; m_drain = 0; m_done = 0; m_fault = 0; m_rd = 32'd0; m_age = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_bus) begin
      fin = ack || err || (TO_EN && m_age == TMO - 1);
      if (fin) begin
        if (!m_drain && !clr) begin
          m_done  = 1;
          m_fault = err || !ack;
          m_rd    = m_fault ? 32'd0 : bus.i_wb_dat;
        end
        m_bus = 0; m_drain = 0;
      end else begin
        m_age++;
        if (clr) m_drain = 1;
      end
    end else if (req && !clr) begin
      m_adr = addr & 32'hFFFF_FFFC;
      m_we  = !ld;
      case (size)
        2'b01:   begin m_sel = addr[1] ? 4'hC : 4'h3; m_dat = {wdata[15:0], wdata[15:0]}; end
        2'b10:   begin m_sel = 4'h1 << addr[1:0]; m_dat = {4{wdata[7:0]}}; end
        default: begin m_sel = 4'hF; m_dat = wdata; end
      endcase
      if ((size == 2'b01 && addr[0]) || ((size == 2'b00 || size == 2'b11) && addr[1:0] != 2'b00)) begin
        m_done = 1; m_fault = 1; m_rd = 32'd0;
      end else begin
        m_bus = 1; m_age = 0; m_drain = 0;
      end
    end
  endtask

  task automatic cyc();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = 1'b0; ld = 1'b0;
    addr = 32'd0; wdata = 32'd0; size = 2'b00;
    bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_dat = 32'd0;
    m_bus = 0; m_drain = 0; m_done = 0; m_fault = 0; m_we = 0; m_age = 0;
    m_rd = 32'd0; m_adr = 32'd0; m_dat = 32'd0; m_sel = 4'd0;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_stb", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("rst_we", {31'd0, bus.o_wb_we}, 32'd0);
    chk("rst_adr", bus.o_wb_adr, 32'd0);
    chk("rst_dat", bus.o_wb_dat, 32'd0);
    chk("rst_sel", {28'd0, bus.o_wb_sel}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    cyc();

    // Word load, ack three cycles after the request.
    stall_hi = 0;
    req = 1'b1; ld = 1'b1; addr = 32'h1000; size = 2'b00;
    cyc();
    req = 1'b0;
    #1 chk("wl_stb", {31'd0, bus.o_wb_stb}, 32'd1);
    chk("wl_sel", {28'd0, bus.o_wb_sel}, 32'hF);
    chk("wl_we", {31'd0, bus.o_wb_we}, 32'd0);
    chk("wl_adr", bus.o_wb_adr, 32'h1000);
    cyc(); cyc();
    bus.i_wb_ack = 1'b1; bus.i_wb_dat = 32'hDEADBEEF;
    cyc();
    bus.i_wb_ack = 1'b0;
    #1 chk("wl_rd", rd, 32'hDEADBEEF);
    chk("wl_fault", {31'd0, fault}, 32'd0);
    chk("wl_stall_done", {31'd0, stall}, 32'd0);
    chk("wl_stall_cycles", stall_hi, 32'd4);
    cyc();

    // Byte store to the top lane.
    req = 1'b1; ld = 1'b0; addr = 32'h2003; wdata = 32'h0000_00AB; size = 2'b10;
    cyc();
    req = 1'b0;
    #1 chk("bs_sel", {28'd0, bus.o_wb_sel}, 32'h8);
    chk("bs_dat", bus.o_wb_dat, 32'hABABABAB);
    chk("bs_we", {31'd0, bus.o_wb_we}, 32'd1);
    chk("bs_adr", bus.o_wb_adr, 32'h2000);
    bus.i_wb_ack = 1'b1; bus.i_wb_dat = 32'h0;
    cyc();
    bus.i_wb_ack = 1'b0;
    cyc();

    // Misaligned half load: no bus cycle, immediate fault.
    req = 1'b1; ld = 1'b1; addr = 32'h2001; size = 2'b01;
    cyc();
    req = 1'b0;
    #1 chk("mh_stb", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("mh_fault", {31'd0, fault}, 32'd1);
    chk("mh_stall", {31'd0, stall}, 32'd0);
    cyc();

    // Flush during the bus cycle, ack two cycles later.
    req = 1'b1; ld = 1'b1; addr = 32'h3000; size = 2'b00;
    cyc();
    req = 1'b0; clr = 1'b1;
    #1 chk("fl_stb0", {31'd0, bus.o_wb_stb}, 32'd1);
    cyc();
    clr = 1'b0;
    #1 chk("fl_stb1", {31'd0, bus.o_wb_stb}, 32'd1);
    cyc();
    bus.i_wb_ack = 1'b1; bus.i_wb_dat = 32'h5555_5555;
    #1 chk("fl_stb2", {31'd0, bus.o_wb_stb}, 32'd1);
    chk("fl_stall2", {31'd0, stall}, 32'd1);
    cyc();
    bus.i_wb_ack = 1'b0;
    #1 chk("fl_stb_off", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("fl_stall_off", {31'd0, stall}, 32'd0);
    chk("fl_fault", {31'd0, fault}, 32'd0);
    chk("fl_rd_kept", rd, 32'd0);
    cyc();

    // ack and err together.
    req = 1'b1; ld = 1'b1; addr = 32'h4000; size = 2'b00;
    cyc();
    req = 1'b0;
    bus.i_wb_ack = 1'b1; bus.i_wb_err = 1'b1; bus.i_wb_dat = 32'h12345678;
    cyc();
    bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0;
    #1 chk("ae_fault", {31'd0, fault}, 32'd1);
    chk("ae_rd", rd, 32'd0);
    cyc();

`ifdef ZAP_MEM_TIMEOUT_EN
    // Unanswered access times out after TMO bus cycles.
    req = 1'b1; ld = 1'b1; addr = 32'h5000; size = 2'b00;
    cyc();
    req = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      #1 chk("to_stb_on", {31'd0, bus.o_wb_stb}, 32'd1);
      cyc();
    end
    #1 chk("to_stb_off", {31'd0, bus.o_wb_stb}, 32'd0);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_rd", rd, 32'd0);
    cyc();
`endif

    // Random traffic with a randomly responding slave, flushes and resets.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom % 200) == 0;
      clr   = ($urandom % 8) == 0;
      req   = $urandom % 2;
      ld    = $urandom % 2;
      addr  = $urandom;
      wdata = $urandom;
      size  = 2'($urandom % 4);
      bus.i_wb_ack = m_bus && (($urandom % 3) == 0);
      bus.i_wb_err = m_bus && (($urandom % 7) == 0);
      bus.i_wb_dat = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
